// File: rtl/key_debounce.sv
// key_debounce
//   Multi-key pushbutton debouncer. Each raw pin is mapped to the logical
//   domain (1 = pressed), passed through a two-flop synchronizer, then
//   filtered by a per-key FSM. The FSM only changes the debounced level once
//   the synchronized input has held its new value for STABLE_TICKS
//   consecutive clken ticks.
//
//   Optional feature macro: KEY_DEBOUNCE_PRESS_PULSE_EN
//     defined   : keypress pulses for one clock on each debounced press
//     undefined : keypress is tied to all-zeros (port list unchanged)
//
// Parameters
//   NKEYS        number of independent keys (1..8)
//   STABLE_TICKS clken ticks a new level must persist (1..255)
//   ACTIVE_LOW   1: raw pin low means pressed; 0: raw pin high means pressed
//
// Ports
//   clock     master clock
//   reset     asynchronous, active-high reset
//   clken     one-clock time-base tick
//   keyraw    asynchronous raw pushbutton pins
//   keyout    debounced level per key, 1 = pressed
//   keypress  one-clock pulse on each debounced press (see macro above)
//
// FSM states (per key)
//   state   | meaning
//   LO      | released, waiting for s2 = 1
//   RISE    | s2 = 1, counting ticks toward press
//   HI      | pressed, waiting for s2 = 0
//   FALL    | s2 = 0, counting ticks toward release
module key_debounce #(
  parameter int NKEYS        = 4,
  parameter int STABLE_TICKS = 5,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clken,
  input  logic [NKEYS-1:0] keyraw,
  output logic [NKEYS-1:0] keyout,
  output logic [NKEYS-1:0] keypress
);

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    ST_RISE = 2'd1,
    ST_HI   = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);

  logic [NKEYS-1:0] key_log;
  logic [NKEYS-1:0] s1_q;
  logic [NKEYS-1:0] s2_q;
  state_t           state_q [NKEYS];
  state_t           state_d [NKEYS];
  logic [7:0]       cnt_q   [NKEYS];
  logic [7:0]       cnt_d   [NKEYS];
  logic [NKEYS-1:0] keyout_q;
  logic [NKEYS-1:0] keyout_d;

  assign key_log = ACTIVE_LOW ? ~keyraw : keyraw;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= key_log;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= ST_LO;
        cnt_q[k]   <= 8'd0;
      end
      keyout_q <= '0;
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      keyout_q <= keyout_d;
    end
  end

  // A reversal of s2 is tested before the tick, so it wins over a terminal
  // tick in the same cycle and aborts the transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    keyout_d = '0;
    for (int k = 0; k < NKEYS; k++) begin
      case (state_q[k])
        ST_LO: begin
          if (s2_q[k]) begin
            state_d[k] = ST_RISE;
            cnt_d[k]   = 8'd0;
          end
        end
        ST_RISE: begin
          if (!s2_q[k]) begin
            state_d[k] = ST_LO;
          end else if (clken && (cnt_q[k] == CNT_LAST)) begin
            state_d[k] = ST_HI;
          end else if (clken) begin
            cnt_d[k] = cnt_q[k] + 8'd1;
          end
        end
        ST_HI: begin
          if (!s2_q[k]) begin
            state_d[k] = ST_FALL;
            cnt_d[k]   = 8'd0;
          end
        end
        ST_FALL: begin
          if (s2_q[k]) begin
            state_d[k] = ST_HI;
          end else if (clken && (cnt_q[k] == CNT_LAST)) begin
            state_d[k] = ST_LO;
          end else if (clken) begin
            cnt_d[k] = cnt_q[k] + 8'd1;
          end
        end
      endcase
      // Registered from the next state so keyout and keypress share an edge.
      keyout_d[k] = (state_d[k] == ST_HI) || (state_d[k] == ST_FALL);
    end
  end

  assign keyout = keyout_q;

`ifdef KEY_DEBOUNCE_PRESS_PULSE_EN
  logic [NKEYS-1:0] press_q;
  logic [NKEYS-1:0] press_d;

  always_comb begin
    press_d = '0;
    for (int k = 0; k < NKEYS; k++) begin
      press_d[k] = (state_q[k] == ST_RISE) && (state_d[k] == ST_HI);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  assign keypress = press_q;
`else
  assign keypress = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int NK = 4;
  localparam int ST = 5;
  localparam int TP = 20;   // clocks per clken tick period (scaled 4 ms)

`ifdef KEY_DEBOUNCE_PRESS_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          clken;
  logic [NK-1:0] keyraw;
  logic [NK-1:0] keyout;
  logic [NK-1:0] keypress;

  key_debounce #(
    .NKEYS       (NK),
    .STABLE_TICKS(ST),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .clken   (clken),
    .keyraw  (keyraw),
    .keyout  (keyout),
    .keypress(keypress)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int ph       = 0;
  int press_cnt [NK];

  // Reference model: a key's output flips once its synchronized input has
  // disagreed with the output for a continuous run containing ST ticks,
  // ignoring any tick in the very first cycle of the run.
  bit m_s1 [NK];
  bit m_s2 [NK];
  bit m_out [NK];
  bit m_press [NK];
  int m_run [NK];
  int m_ticks [NK];

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_out[k] = 0; m_press[k] = 0;
      m_run[k] = 0; m_ticks[k] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [NK-1:0] raw, input bit ck);
    for (int k = 0; k < NK; k++) begin
      m_press[k] = 0;
      if (m_s2[k] != m_out[k]) begin
        if (m_run[k] > 0 && ck) m_ticks[k]++;
        m_run[k]++;
        if (m_ticks[k] == ST) begin
          m_out[k]   = ~m_out[k];
          m_press[k] = PULSE_EN && m_out[k];
          m_run[k]   = 0;
          m_ticks[k] = 0;
        end
      end else begin
        m_run[k]   = 0;
        m_ticks[k] = 0;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = ~raw[k];
    end
  endfunction

  function automatic logic [NK-1:0] m_keyout();
    logic [NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k] = m_out[k];
    return v;
  endfunction

  function automatic logic [NK-1:0] m_keypress();
    logic [NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k] = m_press[k];
    return v;
  endfunction

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic clear_press();
    for (int k = 0; k < NK; k++) press_cnt[k] = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare at negedge.
  task automatic step(input logic [NK-1:0] raw);
    keyraw = raw;
    clken  = (ph == TP - 1);
    @(posedge clock);
    if (reset) model_reset();
    else model_edge(raw, clken);
    ph = (ph + 1) % TP;
    @(negedge clock);
    check("keyout_model", keyout, m_keyout());
    check("keypress_model", keypress, m_keypress());
    for (int k = 0; k < NK; k++) press_cnt[k] += int'(keypress[k]);
  endtask

  task automatic align(input logic [NK-1:0] raw);
    for (int i = 0; i < TP && ph != 0; i++) step(raw);
  endtask

  typedef struct {
    logic [NK-1:0] raw;
    int            periods;
    logic [NK-1:0] exp;
  } row_t;

  row_t tbl [13];

  initial begin
    int lat;
    bit found;
    bit act;
    int ticks;
    logic [NK-1:0] r;

    tbl[0]  = '{4'b1111, 2, 4'b0000};
    tbl[1]  = '{4'b1110, 4, 4'b0000};
    tbl[2]  = '{4'b1110, 1, 4'b0001};
    tbl[3]  = '{4'b1111, 4, 4'b0001};
    tbl[4]  = '{4'b1111, 1, 4'b0000};
    tbl[5]  = '{4'b0111, 2, 4'b0000};
    tbl[6]  = '{4'b0011, 3, 4'b1000};
    tbl[7]  = '{4'b0011, 2, 4'b1100};
    tbl[8]  = '{4'b1011, 2, 4'b1100};
    tbl[9]  = '{4'b1011, 3, 4'b0100};
    tbl[10] = '{4'b1111, 5, 4'b0000};
    tbl[11] = '{4'b1101, 3, 4'b0000};
    tbl[12] = '{4'b1111, 5, 4'b0000};

    reset  = 1'b1;
    keyraw = '1;
    clken  = 1'b0;
    model_reset();
    clear_press();
    #23;
    check("reset_keyout", keyout, 4'b0000);
    check("reset_keypress", keypress, 4'b0000);
    @(negedge clock);
    reset = 1'b0;

    // Table: each row holds a raw pattern for whole tick periods.
    align('1);
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].periods * TP; c++) step(tbl[i].raw);
      check("table_row", keyout, tbl[i].exp);
    end

    // Clean press and release of key 0 with random tick phase.
    repeat ($urandom_range(0, TP - 1)) step('1);
    clear_press();
    found = 0; lat = -1;
    for (int i = 0; i < 200; i++) begin
      step(4'b1110);
      if (!found && keyout[0]) begin found = 1; lat = i + 1; end
    end
    check_int("press_latency", lat, 83, 104);
    check("press_held", keyout, 4'b0001);
    found = 0; lat = -1;
    for (int i = 0; i < 200; i++) begin
      step(4'b1111);
      if (!found && !keyout[0]) begin found = 1; lat = i + 1; end
    end
    check_int("release_latency", lat, 83, 104);
    check("released", keyout, 4'b0000);
    check_int("press_pulses_k0", press_cnt[0], int'(PULSE_EN), int'(PULSE_EN));
    check_int("press_pulses_k1", press_cnt[1], 0, 0);

    // Bounce on key 1 every half tick period, ending pressed.
    repeat ($urandom_range(0, TP - 1)) step('1);
    act = 0;
    for (int i = 0; i < 14; i++) begin
      r = 4'b1111;
      r[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < TP / 2; c++) begin
        step(r);
        if (keyout[1]) act = 1;
      end
    end
    check_int("bounce_quiet", int'(act), 0, 0);
    found = 0; lat = -1;
    for (int i = 0; i < 200; i++) begin
      step(4'b1101);
      if (!found && keyout[1]) begin found = 1; lat = i + 1; end
    end
    check_int("bounce_settle_latency", lat, 83, 104);
    check("bounce_settled", keyout, 4'b0010);
    for (int c = 0; c < 6 * TP; c++) step('1);

    // Release reaches s2 exactly on the terminal tick: transition aborted.
    align('1);
    clear_press();
    for (int c = 0; c < 4 * TP + 17; c++) step(4'b1110);
    for (int c = 0; c < 3; c++) step(4'b1111);
    check("abort_keyout", keyout, 4'b0000);
    for (int c = 0; c < 6 * TP; c++) step(4'b1111);
    check("abort_stays_low", keyout, 4'b0000);
    check_int("abort_no_pulse", press_cnt[0], 0, 0);

    // Randomized segments against the model.
    for (int s = 0; s < 60; s++) begin
      r = 4'($urandom);
      repeat ($urandom_range(1, 120)) step(r);
    end
    for (int c = 0; c < 6 * TP; c++) step('1);
    check("random_idle", keyout, 4'b0000);

    // Reset while pressed drops outputs at once; key held across release.
    for (int c = 0; c < 6 * TP; c++) step(4'b0000);
    check("all_pressed", keyout, 4'b1111);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", keyout, 4'b0000);
    model_reset();
    @(negedge clock);
    for (int c = 0; c < 3; c++) step(4'b0000);
    reset = 1'b0;
    clear_press();
    found = 0; ticks = 0; lat = -1;
    for (int i = 0; i < 8 * TP; i++) begin
      step(4'b0000);
      if (clken) ticks++;
      if (!found && keyout != 4'b0000) begin
        found = 1; lat = ticks;
        check("reset_release_all_keys", keyout, 4'b1111);
      end
    end
    check_int("reset_release_ticks", lat, 5, 6);
    for (int k = 0; k < NK; k++)
      check_int("reset_release_pulses", press_cnt[k], int'(PULSE_EN), int'(PULSE_EN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-key debouncer between the board's raw pushbutton pins and the autorepeat stage. Each key passes through a two-flop synchronizer, then a per-key stability filter timed by the shared clock-enable tick (250 Hz time base). Each key produces a clean level, `keyout`, that feeds the autorepeat `keyin` input directly. An optional one-clock press pulse is also available.

## Interface
- `NKEYS`, default 4: number of independent keys; range 1–8.
- `STABLE_TICKS`, default 5: number of consecutive `clken` ticks the synchronized input must hold a new level before `keyout` follows (5 × 4 ms = 20 ms); range 1–255.
- `ACTIVE_LOW`, default 1: 1 means a raw pin at 0 is "pressed"; 0 means a raw pin at 1 is "pressed".

- `clock` in 1: master clock (50 MHz).
- `reset` in 1: asynchronous, active-high.
- `clken` in 1: time-base tick, one clock wide, 250 Hz.
- `keyraw` in NKEYS: asynchronous raw pushbutton pins.
- `keyout` out NKEYS: debounced level, 1 = pressed.
- `keypress` out NKEYS: one-clock pulse on each debounced press (see Configuration).

## Operation
- **Polarity:** the raw pins are first converted to the logical domain: `ACTIVE_LOW` ? ~keyraw : keyraw.
- **Synchronizer:** two flops per key, `s1` then `s2`. Both reset to 0 (logical not-pressed). The filter uses `s2`.
- **Per-key FSM:** 2-bit state plus an 8-bit counter `cnt`, independent for each key.
  - **LO** (keyout=0): if `s2`=1, go to RISE and clear `cnt`.
  - **RISE** (keyout=0):
    - `s2`=0: return to LO.
    - else, if `clken`=1 and `cnt`==STABLE_TICKS−1: go to HI.
    - else, if `clken`=1: increment `cnt`.
  - **HI** (keyout=1): if `s2`=0, go to FALL and clear `cnt`.
  - **FALL** (keyout=1):
    - `s2`=1: return to HI.
    - else, if `clken`=1 and `cnt`==STABLE_TICKS−1: go to LO.
    - else, if `clken`=1: increment `cnt`.
- **Output decode:** `keyout` is registered and decoded from state as HI|FALL.
- **Press pulse:** `keypress[i]` is asserted for exactly the one clock in which state enters HI from RISE.
- **Simultaneous events:** if an input reversal and the terminal `clken` occur in the same cycle, the reversal wins and the transition is aborted.
- **Counter range:** `cnt` never exceeds STABLE_TICKS−1, so it cannot wrap.
- **Independence:** keys do not interact; any combination may be pressed at once.
- **Clock enable gating:** `clken` high while in LO or HI has no effect.

## Timing
- **Reset values:** `keyout`=0, `keypress`=0, every FSM in LO, `cnt`=0, synchronizer flops 0.
- **Reset mid-filter:** asserting reset in the middle of filtering aborts everything immediately and asynchronously.
- **Release at reset:** a key held down when reset is released is reported after the full filter delay, not immediately.
- **Press latency:** measured from the raw edge, the path is 2 clocks (synchronizer) + 1 clock (LO→RISE) + the time to the STABLE_TICKS-th `clken` tick + 1 clock (register).
  - The filtered duration is between STABLE_TICKS−1 and STABLE_TICKS tick periods, because the first tick may arrive immediately.
- **Release latency:** same as press latency, symmetric.
- **Glitch rejection:** any glitch shorter than STABLE_TICKS−1 tick periods never reaches `keyout`.
- **Edge alignment:** `keypress` rises on the same clock edge as `keyout`.

## Configuration
- **Macro:** `KEY_DEBOUNCE_PRESS_PULSE_EN`.
- **Defined:** `keypress` is generated as described above.
- **Undefined:** the pulse logic is not compiled and `keypress` is tied to all-zeros. The port list is unchanged, and `keyout` behaviour is identical in both cases.

## Test plan
- **Reset with key held:** assert reset with all keys raw-pressed, then release it. Expect `keyout`=0 for at least 4 `clken` ticks, then `keyout`=4'b1111 with a single `keypress`=4'b1111 pulse.
- **Clean press and release:** STABLE_TICKS=5, ACTIVE_LOW=1. Drive `keyraw[0]` low for 40 ms, then high.
  - Expect `keyout[0]` to rise after 16–20 ms and fall 16–20 ms after release.
  - Expect exactly one `keypress[0]` pulse of one clock.
- **Bounce rejection:** toggle `keyraw[1]` every 2 ms for 30 ms, then hold it pressed. Expect no `keyout[1]` activity during the bouncing and one rise 16–20 ms after the last edge.
- **Simultaneous abort:** force `s2` to drop in the same cycle as the terminal `clken`. Expect the FSM back in LO, `keyout` still 0, and no pulse.
- **Independent keys:** press key 2 while key 3 is mid-filter. Expect each output to obey its own timing; other bits stay 0.
- **Macro undefined:** repeat the clean press and release. Expect identical `keyout` behaviour and `keypress`==0 throughout.
